// File: rtl/f_s_rca8_acc.sv
// Frame accumulator: sums LEN signed a+b samples, then holds the result until it is consumed.
// Define ACC_SAT_EN for saturating accumulation with a sticky sat_flag; otherwise the sum wraps.
module f_s_rca8_acc #(
    parameter int LEN   = 4,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clr,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             sat_flag,
    output logic [8:0]       cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
    localparam logic [8:0] LEN_CNT = 9'(LEN);

    logic [1:0]        state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [8:0]        cnt_reg, cnt_next;
    logic              sat_reg, sat_next;
    logic              valid_reg, valid_next;
    // Low until the first edge after reset release, so in_ready stays 0 through reset.
    logic              live_reg;

    logic signed [8:0]       sum9;
    logic signed [ACC_W-1:0] sum_ext;
    logic [ACC_W-1:0]        acc_add;
    logic                    sat_add;
    logic [8:0]              cnt_inc;
    logic                    accept;
    logic                    consume;

    assign sum9    = $signed({a[7], a}) + $signed({b[7], b});
    assign sum_ext = ACC_W'(sum9);
    assign cnt_inc = cnt_reg + 9'd1;

`ifdef ACC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0] acc_wide;
    logic           ovf;

    // One guard bit: overflow shows as disagreement between the top two bits.
    assign acc_wide = {acc_reg[ACC_W-1], acc_reg} + {sum_ext[ACC_W-1], sum_ext};
    assign ovf      = acc_wide[ACC_W] ^ acc_wide[ACC_W-1];
    assign acc_add  = ovf ? (acc_wide[ACC_W] ? ACC_MIN : ACC_MAX) : acc_wide[ACC_W-1:0];
    assign sat_add  = sat_reg | ovf;
`else
    assign acc_add  = acc_reg + sum_ext;
    assign sat_add  = 1'b0;
`endif

    assign in_ready  = live_reg && (state_reg != ST_DONE);
    assign accept    = in_valid && in_ready;
    assign consume   = valid_reg && acc_ready;
    assign acc_out   = acc_reg;
    assign acc_valid = valid_reg;
    assign sat_flag  = sat_reg;
    assign cnt       = cnt_reg;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        sat_next   = sat_reg;
        valid_next = valid_reg;
        // clr outranks both an accept and a consume in the same cycle.
        if (clr) begin
            state_next = ST_IDLE;
            acc_next   = '0;
            cnt_next   = '0;
            sat_next   = 1'b0;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_ACC: begin
                    if (accept) begin
                        acc_next = acc_add;
                        sat_next = sat_add;
                        cnt_next = cnt_inc;
                        if (cnt_inc == LEN_CNT) begin
                            state_next = ST_DONE;
                            valid_next = 1'b1;
                        end else begin
                            state_next = ST_ACC;
                        end
                    end
                end
                ST_DONE: begin
                    if (consume) begin
                        state_next = ST_IDLE;
                        acc_next   = '0;
                        cnt_next   = '0;
                        sat_next   = 1'b0;
                        valid_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    acc_next   = '0;
                    cnt_next   = '0;
                    sat_next   = 1'b0;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            sat_reg   <= 1'b0;
            valid_reg <= 1'b0;
            live_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            sat_reg   <= sat_next;
            valid_reg <= valid_next;
            live_reg  <= 1'b1;
        end
    end

endmodule

// File: doc/f_s_rca8_acc.md
F_S_RCA8_ACC -- requirements
Module: f_s_rca8_acc

Interface
REQ-001 SHALL have parameter LEN, default 4: samples per frame, legal range 1..256.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator width, legal range 9..32.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port a, input, 8: signed two's-complement operand.
REQ-006 SHALL have port b, input, 8: signed two's-complement operand.
REQ-007 SHALL have port in_valid, input, 1: a/b pair offered.
REQ-008 SHALL have port in_ready, output, 1: pair accepted when in_valid && in_ready.
REQ-009 SHALL have port clr, input, 1: synchronous frame abort.
REQ-010 SHALL have port acc_out, output, ACC_W: signed frame result.
REQ-011 SHALL have port acc_valid, output, 1: acc_out holds a completed frame.
REQ-012 SHALL have port acc_ready, input, 1: result consumed when acc_valid && acc_ready.
REQ-013 SHALL have port sat_flag, output, 1: sticky saturation indicator for the current frame.
REQ-014 SHALL have port cnt, output, 9: samples accepted in the current frame.

Function
REQ-015 SHALL form the per-sample sum as the 9-bit signed a+b, sign-extended to ACC_W, never truncated.
REQ-016 SHALL implement states IDLE, ACC, DONE; IDLE and ACC drive in_ready=1, DONE drives in_ready=0.
REQ-017 SHALL, on each accept, update acc <= acc + sum and cnt <= cnt+1, with acc_out reflecting the register.
REQ-018 SHALL move IDLE->ACC on the first accept, and IDLE/ACC->DONE on the accept that makes cnt equal LEN; LEN=1 goes IDLE->DONE directly.
REQ-019 SHALL assert acc_valid exactly one cycle after the LEN-th accept, i.e. registered, latency 1.
REQ-020 SHALL hold acc_out, acc_valid, sat_flag and cnt stable in DONE until acc_ready is high.
REQ-021 SHALL, on acc_valid && acc_ready, clear acc, cnt and sat_flag, deassert acc_valid and enter IDLE; in_valid in that cycle is ignored.
REQ-022 SHALL, on clr high, enter IDLE and clear acc, cnt, sat_flag and acc_valid next edge, taking priority over any simultaneous accept or consume.
REQ-023 SHALL never accept a sample while in DONE; a held in_valid is accepted in the first IDLE cycle.

Reset
REQ-024 SHALL, while rst_n is low, immediately force state=IDLE, acc_out=0, cnt=0, acc_valid=0, sat_flag=0 and in_ready=0.
REQ-025 SHALL drive in_ready=1 from the first rising edge after rst_n deasserts; reset mid-frame discards the partial frame.

Configuration
REQ-026 SHALL, with ACC_SAT_EN defined, clamp acc on overflow to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and set sat_flag until the frame ends.
REQ-027 SHALL, without ACC_SAT_EN, wrap acc modulo 2^ACC_W with sat_flag tied to 0.

Verification
REQ-028 SHALL cover LEN=4, ACC_W=16: (a,b)=(127,127) x4 -> acc_out=0x03F8 (1016), acc_valid one cycle after fourth accept, cnt=4.
REQ-029 SHALL cover LEN=4: (a,b)=(-128,-128) x4 -> acc_out=0xFC00 (-1024), sat_flag=0.
REQ-030 SHALL cover LEN=16, ACC_W=12: (127,127) x16 -> with ACC_SAT_EN acc_out=0x7FF, sat_flag=1; without it acc_out=0xFE0 (-32), sat_flag=0.
REQ-031 SHALL cover acc_ready held low 5 cycles in DONE with in_valid=1 -> acc_out/acc_valid stable, in_ready=0, no accept; accept resumes the cycle after the consume.
REQ-032 SHALL cover clr asserted together with the third accept of a frame -> next cycle IDLE, cnt=0, acc_out=0, no acc_valid.
REQ-033 SHALL cover rst_n pulsed low mid-frame after two accepts -> outputs zero asynchronously; next frame result excludes the pre-reset samples.
